vga_image_scanner: RTL

Scan and timing stage that drives the 128×128×12-bit BRAM image buffer and turns its read data into a 640×480@60 Hz VGA pixel stream. It generates horizontal/vertical counters, derives the buffer's `row`/`col`/`oe` read controls for a centred 2×-upscaled 256×256 window, absorbs the buffer's 1-cycle read latency, and emits aligned sync, data-enable and RGB. It sits directly downstream of the image buffer and upstream of the TMDS/VGA output encoder, clocked by the 25 MHz pixel clock.

---
 rtl/vga_image_scanner.sv | 117 +++++++++++
 1 files changed

// File: rtl/vga_image_scanner.sv
// VGA 640x480@60 scan/timing stage: reads a 2x-upscaled image window from a
// 1-cycle-latency buffer and emits sync, data-enable and RGB aligned to the data.
module vga_image_scanner #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          X0       = 192,
    parameter int          Y0       = 112,
    parameter int          IMG_DIM  = 128,
    parameter logic [11:0] BORDER   = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [6:0]  row,
    output logic [6:0]  col,
    output logic        oe,
    input  logic [11:0] rgb_in,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [11:0] vga_rgb,
    output logic        frame_start
);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_S   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_S   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WX0    = 10'(X0);
    localparam logic [9:0] WX1    = 10'(X0 + 2 * IMG_DIM);
    localparam logic [9:0] WY0    = 10'(Y0);
    localparam logic [9:0] WY1    = 10'(Y0 + 2 * IMG_DIM);

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic img;
    } tmg_t;

    localparam tmg_t TMG_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, img: 1'b0};

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [9:0]  hx, vy;
    logic        in_img, fs_d, fs_q;
    tmg_t        tmg_raw, tmg_d1_q;
    logic        hsync_q, vsync_q, de_q;
    logic [11:0] rgb_d, rgb_q;
    logic        unused_bits;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
    end

    // Buffer address: window-relative position halved gives the 2x upscale.
    assign in_img = (h_q >= WX0) && (h_q < WX1) && (v_q >= WY0) && (v_q < WY1);
    assign hx     = h_q - WX0;
    assign vy     = v_q - WY0;
    assign oe     = in_img;
    assign col    = in_img ? hx[7:1] : 7'd0;
    assign row    = in_img ? vy[7:1] : 7'd0;
    assign unused_bits = ^{hx[9:8], hx[0], vy[9:8], vy[0]};

    assign tmg_raw.de  = (h_q < H_ACT) && (v_q < V_ACT);
    assign tmg_raw.hs  = !((h_q >= HS_S) && (h_q < HS_E));
    assign tmg_raw.vs  = !((v_q >= VS_S) && (v_q < VS_E));
    assign tmg_raw.img = in_img;
    assign fs_d        = (h_q == H_LAST) && (v_q == V_LAST);

    // Stage 2 merges buffer data, which lands alongside the stage-1 timing bits.
    always_comb begin
        rgb_d = 12'h000;
        if (tmg_d1_q.img)     rgb_d = rgb_in;
        else if (tmg_d1_q.de) rgb_d = BORDER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            tmg_d1_q <= TMG_IDLE;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            de_q     <= 1'b0;
            rgb_q    <= '0;
            fs_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            tmg_d1_q <= tmg_raw;
            hsync_q  <= tmg_d1_q.hs;
            vsync_q  <= tmg_d1_q.vs;
            de_q     <= tmg_d1_q.de;
            rgb_q    <= rgb_d;
            fs_q     <= fs_d;
        end
    end

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_de      = de_q;
    assign vga_rgb     = rgb_q;
    assign frame_start = fs_q;
endmodule
